// File: rtl/ddram_if.sv
// DDRAM client port: command, write beat and read return signals.
// The master modport is the memory client; the slave modport is the responder.
interface ddram_if;
    logic        busy;
    logic [7:0]  burstcnt;
    logic [28:0] addr;
    logic        rd;
    logic        we;
    logic [63:0] din;
    logic [7:0]  be;
    logic [63:0] dout;
    logic        dout_ready;

    modport master (
        output burstcnt, addr, rd, we, din, be,
        input  busy, dout, dout_ready
    );

    modport slave (
        input  burstcnt, addr, rd, we, din, be,
        output busy, dout, dout_ready
    );
endinterface

// File: rtl/ddram_responder.sv
// Block-RAM stand-in for a DDRAM client port: burst writes with byte enables,
// fixed-latency burst reads, BUSY back-pressure, optional BUSY injection and error reporting.
module ddram_responder #(
    parameter int          ADDR_BITS   = 12,
    parameter logic [28:0] BASE        = 29'h0C000000,
    parameter int          RD_LATENCY  = 4,
    parameter int          BUSY_PERIOD = 0
) (
    input  logic        DDRAM_CLK,
    input  logic        reset_n,
    ddram_if.slave      ddram,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic        err
);

    localparam int                   DATA_W    = 64;
    localparam int                   DEPTH     = 1 << ADDR_BITS;
    localparam logic [DATA_W-1:0]    OOW_DATA  = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam logic [3:0]           WAIT_INIT = 4'(RD_LATENCY - 2);
    localparam logic [15:0]          BUSY_P    = 16'(BUSY_PERIOD);
    localparam logic [ADDR_BITS-1:0] IDX_ONE   = ADDR_BITS'(1);

    typedef enum logic [1:0] {IDLE, WBURST, RWAIT, RBURST} state_t;

    function automatic logic in_window(input logic [28:0] a);
        return a[28:ADDR_BITS] == BASE[28:ADDR_BITS];
    endfunction

    function automatic logic [7:0] eff_count(input logic [7:0] bc);
        return (bc == 8'd0) ? 8'd1 : bc;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    state_t              state, state_nxt;
    logic                busy, busy_nxt;
    logic [ADDR_BITS-1:0] ptr, ptr_nxt;
    logic [7:0]          rem, rem_nxt;
    logic [3:0]          wait_cnt, wait_nxt;
    logic                oow, oow_nxt;
    logic [15:0]         inj_cnt, inj_nxt;
    logic                inj_hit;

    logic                wr_en;
    logic [ADDR_BITS-1:0] wr_idx;
    logic                beat_en;
    logic                rd_inc, wr_inc, err_set;

    logic [DATA_W-1:0]   dout_reg;
    logic                dout_ready_reg;

    assign ddram.busy       = busy;
    assign ddram.dout       = dout_reg;
    assign ddram.dout_ready = dout_ready_reg;

    assign inj_hit = (BUSY_P != 16'd0) && ((inj_cnt + 16'd1) == BUSY_P);

    always_comb begin
        state_nxt = state;
        busy_nxt  = 1'b0;
        ptr_nxt   = ptr;
        rem_nxt   = rem;
        wait_nxt  = wait_cnt;
        oow_nxt   = oow;
        inj_nxt   = inj_cnt;
        wr_en     = 1'b0;
        wr_idx    = ptr;
        beat_en   = 1'b0;
        rd_inc    = 1'b0;
        wr_inc    = 1'b0;
        err_set   = 1'b0;

        unique case (state)
            IDLE: begin
                // A BUSY cycle in IDLE (post-reset or injected) accepts nothing and just releases
                if (busy) begin
                    busy_nxt = 1'b0;
                end else begin
                    inj_nxt  = (inj_hit || BUSY_P == 16'd0) ? 16'd0 : inj_cnt + 16'd1;
                    busy_nxt = inj_hit;
                    if (ddram.we) begin
                        wr_inc  = 1'b1;
                        wr_en   = in_window(ddram.addr);
                        wr_idx  = ddram.addr[ADDR_BITS-1:0];
                        ptr_nxt = ddram.addr[ADDR_BITS-1:0] + IDX_ONE;
                        oow_nxt = !in_window(ddram.addr);
                        rem_nxt = eff_count(ddram.burstcnt) - 8'd1;
                        err_set = ddram.rd || (ddram.burstcnt == 8'd0) || !in_window(ddram.addr);
                        if (eff_count(ddram.burstcnt) > 8'd1) begin
                            state_nxt = WBURST;
                            busy_nxt  = 1'b0;
                        end
                    end else if (ddram.rd) begin
                        rd_inc    = 1'b1;
                        ptr_nxt   = ddram.addr[ADDR_BITS-1:0];
                        oow_nxt   = !in_window(ddram.addr);
                        rem_nxt   = eff_count(ddram.burstcnt);
                        wait_nxt  = WAIT_INIT;
                        err_set   = (ddram.burstcnt == 8'd0) || !in_window(ddram.addr);
                        state_nxt = RWAIT;
                        busy_nxt  = 1'b1;
                    end
                end
            end

            WBURST: begin
                if (ddram.rd) err_set = 1'b1;
                if (ddram.we) begin
                    wr_inc  = 1'b1;
                    wr_en   = !oow;
                    wr_idx  = ptr;
                    ptr_nxt = ptr + IDX_ONE;
                    rem_nxt = rem - 8'd1;
                    if (rem == 8'd1) state_nxt = IDLE;
                end
            end

            RWAIT: begin
                busy_nxt = 1'b1;
                if (wait_cnt == 4'd0) begin
                    state_nxt = RBURST;
                end else begin
                    wait_nxt = wait_cnt - 4'd1;
                end
            end

            RBURST: begin
                busy_nxt = 1'b1;
                beat_en  = 1'b1;
                ptr_nxt  = ptr + IDX_ONE;
                rem_nxt  = rem - 8'd1;
                // BUSY drops together with the last beat so the next command lands right after it
                if (rem == 8'd1) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge DDRAM_CLK) begin
        if (!reset_n) begin
            state          <= IDLE;
            busy           <= 1'b1;
            dout_ready_reg <= 1'b0;
            rd_count       <= 16'd0;
            wr_count       <= 16'd0;
            err            <= 1'b0;
            inj_cnt        <= 16'd0;
        end else begin
            state          <= state_nxt;
            busy           <= busy_nxt;
            dout_ready_reg <= beat_en;
            inj_cnt        <= inj_nxt;
            if (rd_inc)  rd_count <= rd_count + 16'd1;
            if (wr_inc)  wr_count <= wr_count + 16'd1;
            if (err_set) err      <= 1'b1;
        end
    end

    always_ff @(posedge DDRAM_CLK) begin
        ptr      <= ptr_nxt;
        rem      <= rem_nxt;
        wait_cnt <= wait_nxt;
        oow      <= oow_nxt;
    end

    always_ff @(posedge DDRAM_CLK) begin
        if (wr_en && reset_n) begin
            for (int b = 0; b < 8; b++) begin
                if (ddram.be[b]) mem[wr_idx][8*b +: 8] <= ddram.din[8*b +: 8];
            end
        end
    end

    // Read return register: holds its value between beats
    always_ff @(posedge DDRAM_CLK) begin
        if (!reset_n) begin
            dout_reg <= '0;
        end else if (beat_en) begin
            dout_reg <= oow ? OOW_DATA : mem[ptr];
        end
    end

endmodule
